lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data and register width.
REQ-003 SHALL have parameter REG_ADDR_WIDTH, default 5, register index width.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous and active-low.
REQ-006 SHALL have req_valid/req_ready, in/out, 1/1, request handshake from decode/execute.
REQ-007 SHALL have req_addr, in, ADDR_WIDTH, byte address (ALU result).
REQ-008 SHALL have load_inst, in, 3: 000 none, 001 lb, 010 lh, 011 lw, 100 lbu, 101 lhu.
REQ-009 SHALL have store_mask, in, 4: 0000 none, 0001 sb, 0011 sh, 1111 sw.
REQ-010 SHALL have store_data, in, DATA_WIDTH, unshifted rs2 value.
REQ-011 SHALL have req_rd, in, REG_ADDR_WIDTH, load destination register.
REQ-012 SHALL have mem_valid/mem_ready, out/in, 1/1, memory command handshake.
REQ-013 SHALL have mem_wen, out, 1; mem_addr, out, ADDR_WIDTH, word-aligned; mem_wdata, out, DATA_WIDTH; mem_wstrb, out, 4.
REQ-014 SHALL have mem_rvalid/mem_rdata, in, 1/DATA_WIDTH, read response, single-cycle pulse.
REQ-015 SHALL have w_regW, out, 1; w_regAddr, out, REG_ADDR_WIDTH; w_regData, out, DATA_WIDTH, regfile write port.
REQ-016 SHALL have done, out, 1, completion pulse; err, out, 1, misalignment or illegal-request pulse.

Function
REQ-017 SHALL implement FSM IDLE -> CMD -> RESP -> DONE; req_ready=1 only in IDLE.
REQ-018 SHALL latch all request fields on acceptance (req_valid & req_ready, cycle T); inputs are ignored afterwards until IDLE.
REQ-019 SHALL check the latched request in CMD: both load_inst!=0 and store_mask!=0, unencoded values, lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0 -> skip memory and go to DONE with err=1.
REQ-020 SHALL treat load_inst=000 with store_mask=0000 as a no-op: no memory access, DONE without err.
REQ-021 SHALL assert mem_valid from T+1 and hold it with mem_addr, mem_wen, mem_wdata and mem_wstrb stable until mem_ready.
REQ-022 SHALL form mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}.
REQ-023 SHALL form mem_wstrb = store_mask << addr[1:0] and mem_wdata = store_data << (8*addr[1:0]); mem_wen=1 for stores only.
REQ-024 SHALL go from CMD to DONE for a store on the handshake, and to RESP for a load.
REQ-025 SHALL, in RESP, wait for mem_rvalid, then extract the byte/half at addr[1:0], sign-extend (lb/lh) or zero-extend (lbu/lhu), and go to DONE.
REQ-026 SHALL, in DONE, pulse done for one cycle, plus err if flagged, then return to IDLE; a load with rd!=0 and no err pulses w_regW with w_regAddr=rd and the extracted data in the same cycle.
REQ-027 SHALL never assert w_regW for rd=0, stores, no-ops or errors.
REQ-028 SHALL ignore mem_rvalid outside RESP.
REQ-029 SHALL have minimum latency, with zero-wait memory: load writeback at T+3, store done at T+2, error/no-op done at T+2.

Reset
REQ-030 SHALL, while rst=0, force the IDLE state and all outputs to 0 (req_ready=0), asynchronously.
REQ-031 SHALL, after rst rises, set req_ready=1 in the first clk cycle.
REQ-032 SHALL abandon a reset mid-transaction with no writeback; a late mem_rvalid is discarded.

Structure
REQ-033 SHALL place load_inst/store_mask encodings and the FSM state enum in shared package lsu_pkg.
REQ-034 SHALL place lane shift, wstrb generation and load extraction/extension in combinational sub-module lsu_align.

Verification
REQ-035 SHALL check: lb at addr 0x80000003, mem_rdata 0x80FF1234 -> w_regData 0xFFFFFF80, w_regW at T+3.
REQ-036 SHALL check: lhu at 0x80000002, mem_rdata 0xBEEF0000 -> w_regData 0x0000BEEF.
REQ-037 SHALL check: sb, data 0x000000AB, at 0x80000001 -> mem_wstrb 0010, mem_wdata 0x0000AB00, mem_wen=1, done at T+2.
REQ-038 SHALL check: lw at 0x80000002 -> err and done pulse, mem_valid never asserted, w_regW=0.
REQ-039 SHALL check: lw with rd=0, mem_ready delayed 3 cycles -> mem_valid and mem_addr held stable, done, w_regW=0.
REQ-040 SHALL check: rst low during RESP, then mem_rvalid after release -> outputs 0, no writeback, req_ready=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Contents: load_inst and store_mask encodings, the FSM state enum, and
// req_illegal(), which flags a latched request that must not reach memory.
package lsu_pkg;

    typedef enum logic [2:0] {
        LdNone = 3'b000,
        LdLb   = 3'b001,
        LdLh   = 3'b010,
        LdLw   = 3'b011,
        LdLbu  = 3'b100,
        LdLhu  = 3'b101
    } load_e;

    localparam logic [3:0] SmNone = 4'b0000;
    localparam logic [3:0] SmByte = 4'b0001;
    localparam logic [3:0] SmHalf = 4'b0011;
    localparam logic [3:0] SmWord = 4'b1111;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StResp,
        StDone
    } lsu_state_e;

    // Set for a request that mixes load and store, uses an unencoded value,
    // or is misaligned for its access size.
    function automatic logic req_illegal(input logic [2:0] load_inst,
                                         input logic [3:0] store_mask,
                                         input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (load_inst != LdNone && store_mask != SmNone) begin
            bad = 1'b1;
        end
        case (load_inst)
            LdNone, LdLb, LdLbu: begin end
            LdLh, LdLhu:         if (addr_lo[0]) bad = 1'b1;
            LdLw:                if (addr_lo != 2'b00) bad = 1'b1;
            default:             bad = 1'b1;
        endcase
        case (store_mask)
            SmNone, SmByte: begin end
            SmHalf:         if (addr_lo[0]) bad = 1'b1;
            SmWord:         if (addr_lo != 2'b00) bad = 1'b1;
            default:        bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the LSU (purely combinational).
// Ports:
//   addr_lo    - byte offset within the word
//   load_inst  - load encoding (selects extraction and extension)
//   store_mask - unshifted store byte mask
//   store_data - unshifted store data
//   mem_rdata  - raw memory read word
//   wdata      - store data shifted into its byte lanes
//   wstrb      - store mask shifted into its byte lanes
//   load_data  - extracted and sign/zero-extended load result
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [1:0]            addr_lo,
    input  logic [2:0]            load_inst,
    input  logic [3:0]            store_mask,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [3:0]            wstrb,
    output logic [DATA_WIDTH-1:0] load_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        wstrb = store_mask << addr_lo;
        wdata = store_data << {addr_lo, 3'b000};

        unique case (addr_lo)
            2'd0: lane_b = mem_rdata[7:0];
            2'd1: lane_b = mem_rdata[15:8];
            2'd2: lane_b = mem_rdata[23:16];
            2'd3: lane_b = mem_rdata[31:24];
        endcase
        // Halfwords are only legal at offsets 0 and 2.
        lane_h = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        load_data = '0;
        case (load_inst)
            LdLb:    load_data = {{(DATA_WIDTH-8){lane_b[7]}}, lane_b};
            LdLh:    load_data = {{(DATA_WIDTH-16){lane_h[15]}}, lane_h};
            LdLw:    load_data = mem_rdata;
            LdLbu:   load_data = {{(DATA_WIDTH-8){1'b0}}, lane_b};
            LdLhu:   load_data = {{(DATA_WIDTH-16){1'b0}}, lane_h};
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one request at a time, issues a single memory
// command, aligns store data / extracts load data, and writes loads back.
// Ports:
//   clk, rst (async, active-low)
//   req_*            - request from decode/execute (valid/ready handshake)
//   mem_valid/ready  - memory command handshake; mem_wen/addr/wdata/wstrb
//   mem_rvalid/rdata - single-cycle read response
//   w_regW/regAddr/regData - register file write port
//   done/err         - one-cycle completion and error pulses
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [2:0]                load_inst,
    input  logic [3:0]                store_mask,
    input  logic [DATA_WIDTH-1:0]     store_data,
    input  logic [REG_ADDR_WIDTH-1:0] req_rd,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic                      mem_wen,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [3:0]                mem_wstrb,
    input  logic                      mem_rvalid,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      w_regW,
    output logic [REG_ADDR_WIDTH-1:0] w_regAddr,
    output logic [DATA_WIDTH-1:0]     w_regData,
    output logic                      done,
    output logic                      err
);

    lsu_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [2:0]                load_q;
    logic [3:0]                mask_q;
    logic [DATA_WIDTH-1:0]     sdata_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic                      err_q, err_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;

    logic                  accept;
    logic                  illegal;
    logic                  is_load;
    logic                  is_store;
    logic [DATA_WIDTH-1:0] al_wdata;
    logic [3:0]            al_wstrb;
    logic [DATA_WIDTH-1:0] al_load;

    lsu_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .addr_lo    (addr_q[1:0]),
        .load_inst  (load_q),
        .store_mask (mask_q),
        .store_data (sdata_q),
        .mem_rdata  (mem_rdata),
        .wdata      (al_wdata),
        .wstrb      (al_wstrb),
        .load_data  (al_load)
    );

    // Gated by rst so req_ready drops the moment reset asserts.
    assign req_ready = rst && (state_q == StIdle);
    assign accept    = req_valid && req_ready;
    assign is_load   = (load_q != LdNone);
    assign is_store  = (mask_q != SmNone);
    assign illegal   = req_illegal(load_q, mask_q, addr_q[1:0]);

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        mem_valid = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        w_regW    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    err_d   = 1'b0;
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (illegal) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else if (!is_load && !is_store) begin
                    state_d = StDone;
                end else begin
                    mem_valid = 1'b1;
                    if (mem_ready) begin
                        state_d = is_load ? StResp : StDone;
                    end
                end
            end
            StResp: begin
                if (mem_rvalid) begin
                    rdata_d = al_load;
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                err     = err_q;
                w_regW  = is_load && !err_q && (rd_q != '0);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Memory and writeback buses read as zero whenever they are not in use.
        mem_wen   = mem_valid && is_store;
        mem_addr  = mem_valid ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
        mem_wdata = mem_valid ? al_wdata : '0;
        mem_wstrb = mem_valid ? al_wstrb : 4'b0000;
        w_regAddr = w_regW ? rd_q : '0;
        w_regData = w_regW ? rdata_q : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            load_q  <= '0;
            mask_q  <= '0;
            sdata_q <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            if (accept) begin
                addr_q  <= req_addr;
                load_q  <= load_inst;
                mask_q  <= store_mask;
                sdata_q <= store_data;
                rd_q    <= req_rd;
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  load_inst;
    logic [3:0]  store_mask;
    logic [31:0] store_data;
    logic [4:0]  req_rd;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        w_regW;
    logic [4:0]  w_regAddr;
    logic [31:0] w_regData;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    lsu #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .load_inst  (load_inst),
        .store_mask (store_mask),
        .store_data (store_data),
        .req_rd     (req_rd),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .w_regW     (w_regW),
        .w_regAddr  (w_regAddr),
        .w_regData  (w_regData),
        .done       (done),
        .err        (err)
    );

    int total = 0;
    int bad   = 0;

    // Expected outputs for the current cycle, set by the stimulus process.
    logic        chk_en = 1'b0;
    logic        exp_zero;
    logic        exp_store;
    logic        exp_req_ready;
    logic        exp_mem_valid;
    logic        exp_mem_wen;
    logic [31:0] exp_mem_addr;
    logic [31:0] exp_mem_wdata;
    logic [3:0]  exp_mem_wstrb;
    logic        exp_done;
    logic        exp_err;
    logic        exp_w_regW;
    logic [4:0]  exp_w_regAddr;
    logic [31:0] exp_w_regData;

    typedef struct packed {
        logic        is_err;
        logic        is_mem;
        logic        is_store;
        logic        is_load;
        logic [31:0] mem_addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] wb;
    } pred_t;

    // Reference model: what a request must do, from its encoding alone.
    function automatic pred_t predict(input logic [2:0] li, input logic [3:0] sm,
                                      input logic [31:0] addr, input logic [31:0] sd,
                                      input logic [31:0] rdata);
        pred_t p;
        int off;
        int size;
        bit sgn;
        logic [31:0] m;
        p = '0;
        off = int'(addr % 32'd4);
        size = 0;
        sgn = 1'b0;
        p.mem_addr = addr & 32'hFFFF_FFFC;
        case (li)
            3'd1: begin size = 1; sgn = 1'b1; end
            3'd2: begin size = 2; sgn = 1'b1; end
            3'd3: size = 4;
            3'd4: size = 1;
            3'd5: size = 2;
            default: size = 0;
        endcase
        if (li > 3'd5 || !(sm inside {4'd0, 4'd1, 4'd3, 4'd15}) || (li != 0 && sm != 0)) begin
            p.is_err = 1'b1;
        end else if (li == 0 && sm == 0) begin
            p.is_err = 1'b0;
        end else begin
            if (sm != 0) size = (sm == 4'd1) ? 1 : (sm == 4'd3) ? 2 : 4;
            if (off % size != 0) begin
                p.is_err = 1'b1;
            end else if (sm != 0) begin
                p.is_mem   = 1'b1;
                p.is_store = 1'b1;
                p.wstrb    = 4'(((1 << size) - 1) << off);
                p.wdata    = sd << (8 * off);
            end else begin
                p.is_mem  = 1'b1;
                p.is_load = 1'b1;
                m = (size == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * size)) - 32'h1;
                p.wb = (rdata >> (8 * off)) & m;
                if (sgn && p.wb[8 * size - 1]) p.wb = p.wb | ~m;
            end
        end
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(exp_req_ready));
            chk("mem_valid", 32'(mem_valid), 32'(exp_mem_valid));
            chk("done",      32'(done),      32'(exp_done));
            chk("err",       32'(err),       32'(exp_err));
            chk("w_regW",    32'(w_regW),    32'(exp_w_regW));
            if (exp_mem_valid || exp_zero) begin
                chk("mem_wen",   32'(mem_wen),   32'(exp_mem_wen));
                chk("mem_addr",  mem_addr,       exp_mem_addr);
                chk("mem_wstrb", 32'(mem_wstrb), 32'(exp_mem_wstrb));
            end
            if ((exp_mem_valid && exp_store) || exp_zero) begin
                chk("mem_wdata", mem_wdata, exp_mem_wdata);
            end
            if (exp_w_regW || exp_zero) begin
                chk("w_regAddr", 32'(w_regAddr), 32'(exp_w_regAddr));
                chk("w_regData", w_regData,      exp_w_regData);
            end
        end
    end

    task automatic set_exp_quiet(input logic ready);
        exp_zero      = 1'b0;
        exp_store     = 1'b0;
        exp_req_ready = ready;
        exp_mem_valid = 1'b0;
        exp_mem_wen   = 1'b0;
        exp_mem_addr  = '0;
        exp_mem_wdata = '0;
        exp_mem_wstrb = '0;
        exp_done      = 1'b0;
        exp_err       = 1'b0;
        exp_w_regW    = 1'b0;
        exp_w_regAddr = '0;
        exp_w_regData = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic [2:0] li, input logic [3:0] sm, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [4:0] rd, input int rdy_dly,
                       input logic [31:0] rdata, input int rv_dly);
        pred_t p;
        p = predict(li, sm, addr, sd, rdata);
        // Cycle T: request accepted.
        set_exp_quiet(1'b1);
        req_valid  = 1'b1;
        load_inst  = li;
        store_mask = sm;
        req_addr   = addr;
        store_data = sd;
        req_rd     = rd;
        next_cycle();
        // Scramble the request inputs: the DUT must use its latched copy.
        req_valid  = 1'b0;
        load_inst  = 3'($urandom);
        store_mask = 4'($urandom);
        req_addr   = $urandom;
        store_data = $urandom;
        req_rd     = 5'($urandom);
        set_exp_quiet(1'b0);
        if (p.is_mem) begin
            for (int k = 0; k <= rdy_dly; k++) begin
                exp_mem_valid = 1'b1;
                exp_store     = p.is_store;
                exp_mem_wen   = p.is_store;
                exp_mem_addr  = p.mem_addr;
                exp_mem_wdata = p.wdata;
                exp_mem_wstrb = p.wstrb;
                mem_ready     = (k == rdy_dly);
                mem_rvalid    = (k < rdy_dly);  // stray responses while commanding
                mem_rdata     = $urandom;
                next_cycle();
            end
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            set_exp_quiet(1'b0);
            if (p.is_load) begin
                for (int k = 0; k <= rv_dly; k++) begin
                    mem_rvalid = (k == rv_dly);
                    mem_rdata  = (k == rv_dly) ? rdata : $urandom;
                    next_cycle();
                end
                mem_rvalid = 1'b0;
            end
        end else begin
            next_cycle();
        end
        // Completion cycle.
        exp_done      = 1'b1;
        exp_err       = p.is_err;
        exp_w_regW    = p.is_load && (rd != 5'd0);
        exp_w_regAddr = rd;
        exp_w_regData = p.wb;
        next_cycle();
        set_exp_quiet(1'b1);
    endtask

    initial begin
        pred_t p;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        load_inst  = '0;
        store_mask = '0;
        store_data = '0;
        req_rd     = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        set_exp_quiet(1'b0);
        exp_zero = 1'b1;
        chk_en   = 1'b1;
        repeat (2) next_cycle();
        rst = 1'b1;
        set_exp_quiet(1'b1);
        next_cycle();

        // Hand-computed values that pin the model.
        p = predict(3'd1, 4'd0, 32'h8000_0003, 32'h0, 32'h80FF_1234);
        chk("model_lb", p.wb, 32'hFFFF_FF80);
        p = predict(3'd5, 4'd0, 32'h8000_0002, 32'h0, 32'hBEEF_0000);
        chk("model_lhu", p.wb, 32'h0000_BEEF);
        p = predict(3'd0, 4'd1, 32'h8000_0001, 32'h0000_00AB, 32'h0);
        chk("model_sb_wdata", p.wdata, 32'h0000_AB00);
        chk("model_sb_wstrb", 32'(p.wstrb), 32'h2);
        p = predict(3'd3, 4'd0, 32'h8000_0002, 32'h0, 32'h0);
        chk("model_lw_mis", 32'(p.is_err), 32'h1);

        //  li     sm     addr          sdata         rd  rdy rdata         rv
        txn(3'd1, 4'd0,  32'h8000_0003, 32'h0,        5'd5,  0, 32'h80FF_1234, 0);
        txn(3'd5, 4'd0,  32'h8000_0002, 32'h0,        5'd6,  0, 32'hBEEF_0000, 0);
        txn(3'd0, 4'd1,  32'h8000_0001, 32'h0000_00AB, 5'd9, 0, 32'h0,         0);
        txn(3'd3, 4'd0,  32'h8000_0002, 32'h0,        5'd3,  0, 32'h0,         0);
        txn(3'd3, 4'd0,  32'h8000_0004, 32'h0,        5'd0,  3, 32'hCAFE_F00D, 0);
        txn(3'd2, 4'd0,  32'h8000_0000, 32'h0,        5'd10, 0, 32'h1234_8001, 0);
        txn(3'd4, 4'd0,  32'h8000_0002, 32'h0,        5'd11, 0, 32'h00C3_0000, 1);
        txn(3'd0, 4'd3,  32'h8000_0002, 32'h0000_BEEF, 5'd12, 0, 32'h0,        0);
        txn(3'd0, 4'd15, 32'h8000_0008, 32'hDEAD_BEEF, 5'd13, 2, 32'h0,        0);
        txn(3'd3, 4'd0,  32'h8000_000C, 32'h0,        5'd31, 0, 32'h7654_3210, 2);
        txn(3'd0, 4'd0,  32'h8000_0010, 32'h0,        5'd4,  0, 32'h0,         0);
        txn(3'd1, 4'd1,  32'h8000_0000, 32'h0,        5'd4,  0, 32'h0,         0);
        txn(3'd6, 4'd0,  32'h8000_0000, 32'h0,        5'd4,  0, 32'h0,         0);
        txn(3'd0, 4'd3,  32'h8000_0003, 32'h1234,     5'd4,  0, 32'h0,         0);
        txn(3'd0, 4'd7,  32'h8000_0000, 32'h1234,     5'd4,  0, 32'h0,         0);
        txn(3'd2, 4'd0,  32'h8000_0002, 32'h0,        5'd14, 0, 32'h7FFF_0000, 0);
        txn(3'd1, 4'd0,  32'h8000_0000, 32'h0,        5'd15, 0, 32'h0000_007F, 0);

        // Reset while waiting for a load response, then a late response.
        set_exp_quiet(1'b1);
        req_valid  = 1'b1;
        load_inst  = 3'd3;
        store_mask = 4'd0;
        req_addr   = 32'h8000_0010;
        store_data = '0;
        req_rd     = 5'd7;
        next_cycle();
        req_valid = 1'b0;
        set_exp_quiet(1'b0);
        exp_mem_valid = 1'b1;
        exp_mem_addr  = 32'h8000_0010;
        mem_ready     = 1'b1;
        next_cycle();
        mem_ready = 1'b0;
        set_exp_quiet(1'b0);
        next_cycle();
        rst = 1'b0;
        set_exp_quiet(1'b0);
        exp_zero = 1'b1;
        next_cycle();
        rst = 1'b1;
        set_exp_quiet(1'b1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        next_cycle();
        mem_rvalid = 1'b0;
        next_cycle();
        next_cycle();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
